adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Synthesizable emulator of the serial ADC on the audio board's SPI bus: the responder end of the adconv/sck/miso capture interface that topaudio drives as master.
- On an adconv rising edge, latches two 14-bit channel samples, then shifts a 34-bit ADC-format frame out on miso, one bit per sck falling edge.
- Used for on-chip loopback and for the bench model that replaces the free-running miso toggle.

Parameters:
- DATA_W, 14, bits per channel sample (two's complement, MSB first).
- GAP_BITS, 2, zero bits before ch0, between channels, and after ch1.
- SYNC_STAGES, 2, synchronizer depth on sck and adconv (minimum 2).

Ports:
- clock  in  1  system clock (50 MHz on board, 10 MHz in bench).
- reset_n  in  1  asynchronous active-low reset.
- ch0_sample  in  DATA_W  channel 0 value; sampled on adconv rise.
- ch1_sample  in  DATA_W  channel 1 value; sampled on adconv rise.
- sck  in  1  SPI clock from master; asynchronous to clock.
- adconv  in  1  conversion strobe from master; asynchronous to clock.
- miso  out  1  serial data to master (registered).
- miso_oe  out  1  high while a frame is being driven; top level tristates miso when low.
- busy  out  1  high from frame start until the last bit is shifted.
- frame_done  out  1  one-clock pulse when a frame completes.
- overrun  out  1  one-clock pulse when adconv rises during an active frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; bit_cnt 0; shift register 0; synchronizer flops 0.
- sck and adconv each pass through SYNC_STAGES flops. One further flop provides edge detection, giving sck_fall and conv_rise single-cycle strobes.
- FRAME_LEN = 3*GAP_BITS + 2*DATA_W = 34 with defaults. Shift register width = FRAME_LEN.
- Frame contents, bit index 0 sent first:
  - bits 0..1 = 0
  - bits 2..15 = ch0_sample MSB..LSB
  - bits 16..17 = 0
  - bits 18..31 = ch1_sample MSB..LSB
  - bits 32..33 = 0
- States:
  - IDLE: miso=0, miso_oe=0, busy=0. On conv_rise: load shift register, bit_cnt=0, go to LOAD.
  - LOAD: one cycle. miso=frame bit 0, miso_oe=1, busy=1, go to SHIFT.
  - SHIFT: on each sck_fall, bit_cnt++ and miso = frame bit bit_cnt+1. On the sck_fall with bit_cnt==FRAME_LEN-1: go to IDLE, pulse frame_done, then miso=0 and miso_oe=0.
- miso changes exactly SYNC_STAGES+1 clock cycles after the sck falling edge at the pin.
- sck timing constraint: high and low times must each be at least SYNC_STAGES+2 clock periods. Behaviour is undefined below this; no detection is required.
- sck edges in IDLE are ignored. An sck_fall in the LOAD cycle is not possible under the constraint above.
- conv_rise during LOAD or SHIFT:
  - pulse overrun
  - reload the shift register with the current samples, bit_cnt=0, re-enter LOAD
  - no frame_done pulse for the aborted frame
- conv_rise and the final sck_fall in the same cycle: frame_done pulses, overrun does not, and the new frame loads (conv wins the next state).
- adconv level while high has no effect. Only rising edges matter.
- ch0_sample and ch1_sample may change at any time after the conv_rise cycle without affecting the frame in flight.
- Reset asserted mid-frame: immediate return to IDLE, miso_oe=0, no frame_done.

Decomposition:
- Shared package adc_spi_pkg:
  - FRAME_LEN function of DATA_W and GAP_BITS
  - state enum (IDLE, LOAD, SHIFT)
  - bit-counter width: $clog2(FRAME_LEN)
- One sub-module, sync_edge_det: SYNC_STAGES synchronizer plus rise/fall strobes. Instantiated twice, for sck and adconv.

Test Plan:
- Reset: hold reset_n=0 with sck and adconv toggling -> miso=0, miso_oe=0, busy=0, no pulses. Release -> stays IDLE.
- Nominal frame: ch0=14'h2ABC, ch1=14'h1234, 10 MHz clock, sck period 1 us, adconv pulse, 34 sck falls -> master captures on rising edges 00_10101010111100_00_01001000110100_00. frame_done one pulse after the 34th fall. miso_oe low afterwards.
- Latency: single sck fall -> miso update exactly SYNC_STAGES+1=3 clocks later. Check with a cycle-accurate monitor.
- Extremes: ch0=14'h2000, ch1=14'h1FFF -> bits 2..15 = 1 then 13 zeros; bits 18..31 = 0 then 13 ones.
- Overrun: adconv rises after 10 sck falls -> overrun pulse, frame restarts at bit 0 with newly latched samples. Exactly one frame_done after 34 further falls.
- Reset mid-frame: assert reset_n after 20 falls -> miso_oe drops asynchronously. A subsequent adconv rise produces a full correct frame.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared frame geometry and FSM encoding for the ADC SPI responder.
package adc_spi_pkg;

    localparam int DEF_DATA_W   = 14;
    localparam int DEF_GAP_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    function automatic int frame_len(input int data_w, input int gap_bits);
        return 3 * gap_bits + 2 * data_w;
    endfunction

    function automatic int cnt_width(input int data_w, input int gap_bits);
        return $clog2(frame_len(data_w, gap_bits));
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus a one-cycle edge strobe.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2,
    parameter bit DETECT_FALL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= w_level;
        end
    end

    // Strobe is combinational from flops so the consumer registers it one cycle later.
    assign o_edge = DETECT_FALL ? (r_prev & ~w_level) : (~r_prev & w_level);

endmodule

// File: rtl/adc_spi_responder.sv
// Responder side of the serial ADC link: latches two samples on adconv rise and
// shifts a gap-padded frame out on miso, one bit per sck falling edge.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int GAP_BITS    = DEF_GAP_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] i_ch0_sample,
    input  logic [DATA_W-1:0] i_ch1_sample,
    input  logic              i_sck,
    input  logic              i_adconv,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overrun
);

    localparam int FRAME_LEN = frame_len(DATA_W, GAP_BITS);
    localparam int CNT_W     = cnt_width(DATA_W, GAP_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_LOAD  = ST_LOAD;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;

    logic                 w_sck_fall;
    logic                 w_conv_rise;
    logic                 w_last_fall;
    logic [FRAME_LEN-1:0] w_frame;

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [FRAME_LEN-1:0] r_shift;
    logic                 r_miso;
    logic                 r_miso_oe;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_overrun;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .DETECT_FALL(1'b1)) u_sck_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_sck),
        .o_edge    (w_sck_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .DETECT_FALL(1'b0)) u_conv_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_adconv),
        .o_edge    (w_conv_rise)
    );

    // Frame bit 0 goes out first; each channel is placed MSB first after its gap.
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_frame
            if (gi >= GAP_BITS && gi < GAP_BITS + DATA_W) begin : g_ch0
                assign w_frame[gi] = i_ch0_sample[GAP_BITS + DATA_W - 1 - gi];
            end else if (gi >= 2*GAP_BITS + DATA_W && gi < 2*GAP_BITS + 2*DATA_W) begin : g_ch1
                assign w_frame[gi] = i_ch1_sample[2*GAP_BITS + 2*DATA_W - 1 - gi];
            end else begin : g_gap
                assign w_frame[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_last_fall = w_sck_fall && (r_bit_cnt == LAST_CNT);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_conv_rise) begin
                        r_shift   <= w_frame;
                        r_bit_cnt <= '0;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_conv_rise) begin
                        r_overrun <= 1'b1;
                        r_shift   <= w_frame;
                        r_bit_cnt <= '0;
                    end else begin
                        r_miso    <= r_shift[0];
                        r_miso_oe <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_last_fall) begin
                        r_frame_done <= 1'b1;
                        r_miso       <= 1'b0;
                        r_miso_oe    <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_sck_fall) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        r_miso    <= r_shift[1];
                        r_shift   <= r_shift >> 1;
                    end
                    // A new conversion restarts the frame; completing the old one suppresses overrun.
                    if (w_conv_rise) begin
                        r_overrun <= !w_last_fall;
                        r_shift   <= w_frame;
                        r_bit_cnt <= '0;
                        r_state   <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_miso       = r_miso;
    assign o_miso_oe    = r_miso_oe;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench: stimulus queues expected frames/overruns, a negedge monitor checks them.
module tb_adc_spi_responder;

    localparam logic [33:0] NOM_FRAME = 34'b00_10101010111100_00_01001000110100_00;
    localparam logic [33:0] EXT_FRAME = 34'b00_10000000000000_00_01111111111111_00;
    localparam logic [33:0] OVR_FRAME = 34'b00_00111100001111_00_11000000000011_00;
    localparam logic [33:0] RST_FRAME = 34'b00_01010101010101_00_10101010101010_00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] ch0 = '0;
    logic [13:0] ch1 = '0;
    logic        sck = 1'b0;
    logic        conv = 1'b0;
    logic        miso, oe, busy, done, ovr;

    always #50 clk = ~clk;

    adc_spi_responder dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_ch0_sample (ch0),
        .i_ch1_sample (ch1),
        .i_sck        (sck),
        .i_adconv     (conv),
        .o_miso       (miso),
        .o_miso_oe    (oe),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_overrun    (ovr)
    );

    logic [33:0] frame_q[$];
    int          ovr_q[$];
    int          checks = 0;
    int          errors = 0;

    // Requests from stimulus to monitor (written only by stimulus).
    int          idle_req = 0;
    int          async_req = 0;
    logic [2:0]  async_outs = '0;
    int          end_req = 0;

    // Monitor state (written only by monitor).
    int          end_ack = 0;
    int          idle_seen = 0;
    int          async_seen = 0;
    logic        prev_sck = 1'b0, prev_conv = 1'b0, prev_miso = 1'b0, prev_oe = 1'b0, post_done = 1'b0;
    int          since = 99, conv_since = 99;
    logic [33:0] cap = '0;
    int          cap_n = 0;
    logic [33:0] exp_frame;
    int          ovr_tok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h at %0t", name, act, $time);
        end
    endtask

    always @(negedge clk) begin
        if (prev_sck && !sck) since = 0;
        else if (since < 99) since++;
        if (!prev_conv && conv) begin
            conv_since = 0;
            cap_n = 0;
        end else if (conv_since < 99) begin
            conv_since++;
        end

        if (!rst_n) begin
            chk("reset_outputs", {59'd0, miso, oe, busy, done, ovr}, 64'd0);
            cap_n = 0;
            post_done = 1'b0;
        end else begin
            if (!prev_sck && sck && oe) begin
                cap = {cap[32:0], miso};
                cap_n++;
            end
            // The LOAD cycle after a restart may change miso without a recent sck fall.
            if (oe && prev_oe && (miso != prev_miso) && conv_since != 4)
                chk("miso_latency", since, 3);
            if (post_done) chk("oe_after_done", oe, 0);
            post_done = done;
            if (done) begin
                chk("done_latency", since, 3);
                chk("frame_expected", frame_q.size() > 0, 1);
                if (frame_q.size() > 0) begin
                    exp_frame = frame_q.pop_front();
                    chk("frame_bits", cap_n, 34);
                    chk("frame_data", cap, exp_frame);
                end
            end
            if (ovr) begin
                chk("overrun_expected", ovr_q.size() > 0, 1);
                if (ovr_q.size() > 0) ovr_tok = ovr_q.pop_front();
                chk("overrun_latency", conv_since, 3);
            end
        end

        if (idle_req != idle_seen) begin
            idle_seen = idle_req;
            chk("idle_outputs", {61'd0, miso, oe, busy}, 64'd0);
        end
        if (async_req != async_seen) begin
            async_seen = async_req;
            chk("async_reset_outputs", {61'd0, async_outs}, 64'd0);
        end
        if (end_req != 0 && end_ack == 0) begin
            chk("frames_left", frame_q.size(), 0);
            chk("overruns_left", ovr_q.size(), 0);
            end_ack = 1;
        end

        prev_sck  = sck;
        prev_conv = conv;
        prev_miso = miso;
        prev_oe   = oe;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sck_bits(input int n);
        repeat (n) begin
            sck = 1'b1;
            clks(5);
            sck = 1'b0;
            clks(5);
        end
    endtask

    task automatic start_frame(input logic [13:0] a, input logic [13:0] b,
                               input logic push, input logic [33:0] exp);
        ch0 = a;
        ch1 = b;
        if (push) frame_q.push_back(exp);
        clks(2);
        conv = 1'b1;
        clks(6);
        conv = 1'b0;
        clks(4);
    endtask

    initial begin
        clks(1);
        for (int i = 0; i < 12; i++) begin
            sck = ~sck;
            if (i % 3 == 0) conv = ~conv;
            clks(2);
        end
        sck  = 1'b0;
        conv = 1'b0;
        clks(4);
        rst_n = 1'b1;
        clks(10);
        idle_req++;
        clks(2);

        start_frame(14'h2ABC, 14'h1234, 1'b1, NOM_FRAME);
        sck_bits(34);
        clks(4);
        idle_req++;

        start_frame(14'h2000, 14'h1FFF, 1'b1, EXT_FRAME);
        sck_bits(34);
        clks(4);
        idle_req++;

        start_frame(14'h3FFF, 14'h3FFF, 1'b0, '0);
        sck_bits(10);
        ovr_q.push_back(1);
        start_frame(14'h0F0F, 14'h3003, 1'b1, OVR_FRAME);
        sck_bits(34);
        clks(4);
        idle_req++;

        start_frame(14'h1234, 14'h0777, 1'b0, '0);
        sck_bits(20);
        rst_n = 1'b0;
        #1;
        async_outs = {miso, oe, busy};
        async_req++;
        clks(3);
        rst_n = 1'b1;
        clks(5);
        idle_req++;
        start_frame(14'h1555, 14'h2AAA, 1'b1, RST_FRAME);
        sck_bits(34);
        clks(4);
        idle_req++;

        clks(2);
        end_req = 1;
        for (int i = 0; i < 20 && end_ack == 0; i++) clks(1);
        if (end_ack == 0) begin
            $display("FAIL end_handshake actual=0 required=1");
            $fatal(1, "monitor did not respond");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
